// File: rtl/arcade_dl_router_pkg.sv
// Shared types and download index constants for the arcade download router.
package arcade_dl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN
  } dl_state_t;

  localparam logic [7:0] IDX_ROM  = 8'd0;
  localparam logic [7:0] IDX_MOD  = 8'd1;
  localparam logic [7:0] IDX_WAVE = 8'd2;
  localparam logic [7:0] IDX_DIP  = 8'd254;

endpackage

// File: rtl/arcade_dl_router_if.sv
// hps_io download bus plus per-region sink handshake.
// master = download source and region sinks, slave = router.
interface arcade_dl_router_if #(
  parameter int NREG = 3,
  parameter int AW   = 25
);
  logic            ioctl_download;
  logic            ioctl_wr;
  logic [7:0]      ioctl_index;
  logic [AW-1:0]   ioctl_addr;
  logic [7:0]      ioctl_dout;
  logic            ioctl_wait;
  logic [NREG-1:0] sink_wr;
  logic [AW-1:0]   sink_addr;
  logic [7:0]      sink_data;
  logic [NREG-1:0] sink_ready;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout, sink_ready,
    input  ioctl_wait, sink_wr, sink_addr, sink_data
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout, sink_ready,
    output ioctl_wait, sink_wr, sink_addr, sink_data
  );
endinterface

// File: rtl/arcade_dl_router_skid_buf.sv
// One-entry region write buffer: holds addr/data and a one-hot strobe until
// the addressed sink accepts, back-pressuring hps_io through ioctl_wait.
module dl_skid_buf #(
  parameter int NREG = 3,
  parameter int AW   = 25,
  parameter int IW   = 2
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [AW-1:0]   wr_addr,
  input  logic [7:0]      wr_data,
  input  logic [NREG-1:0] sink_ready,
  output logic [NREG-1:0] sink_wr,
  output logic [AW-1:0]   sink_addr,
  output logic [7:0]      sink_data,
  output logic            ioctl_wait
);

  logic          full;
  logic [IW-1:0] idx_q;
  logic          accept;

  always_comb begin
    sink_wr = '0;
    for (int i = 0; i < NREG; i++) begin
      sink_wr[i] = full && (idx_q == IW'(i));
    end
  end

  assign accept     = |(sink_wr & sink_ready);
  assign ioctl_wait = full && !accept;

  // A slot freed by an accept this cycle can take a new write immediately.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      full      <= 1'b0;
      idx_q     <= '0;
      sink_addr <= '0;
      sink_data <= '0;
    end else if (wr_en && (!full || accept)) begin
      full      <= 1'b1;
      idx_q     <= wr_idx;
      sink_addr <= wr_addr;
      sink_data <= wr_data;
    end else if (accept) begin
      full <= 1'b0;
    end
  end

  overflow_chk: assert property (@(posedge clk_sys) disable iff (reset)
                                 !(wr_en && full && !accept))
    else $error("dl_skid_buf: write dropped, buffer full");

endmodule

// File: rtl/arcade_dl_router.sv
// Routes hps_io downloads to region sinks, DIP/mod registers and core reset.
// Optional DL_CHECKSUM_EN adds a per-download sum of accepted region bytes.
module arcade_dl_router
  import arcade_dl_pkg::*;
#(
  parameter int              NREG     = 3,
  parameter int              AW       = 25,
  parameter int              DIPB     = 8,
  parameter int              HOLD     = 1024,
  parameter logic [NREG-1:0] REQ_MASK = NREG'(4)
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  arcade_dl_router_if.slave    bus,
  output logic [8*DIPB-1:0]    dip,
  output logic [7:0]           mod,
  output logic                 core_reset,
  output logic [NREG-1:0]      loaded
`ifdef DL_CHECKSUM_EN
  ,
  output logic [7:0]           csum,
  output logic                 csum_valid
`endif
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int CW = $clog2(HOLD + 1);

  dl_state_t       state;
  logic            dl_q;
  logic [7:0]      idx_q;
  logic [CW-1:0]   hold_cnt;
  logic            dl_rise;
  logic            dl_fall;
  logic            wr_strobe;
  logic            region_wr;
  logic [NREG-1:0] loaded_next;
  logic            all_req;

  assign dl_rise   = bus.ioctl_download && !dl_q;
  assign dl_fall   = !bus.ioctl_download && dl_q;
  assign wr_strobe = bus.ioctl_download && bus.ioctl_wr;
  assign region_wr = wr_strobe && (bus.ioctl_index < 8'(NREG));

  always_comb begin
    loaded_next = loaded;
    for (int i = 0; i < NREG; i++) begin
      if (dl_fall && (idx_q == 8'(i))) loaded_next[i] = 1'b1;
    end
  end

  assign all_req = ((loaded_next & REQ_MASK) == REQ_MASK);

  // Any new download aborts HOLD/RUN; core only leaves reset after HOLD cycles.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      core_reset <= 1'b1;
      dl_q       <= 1'b0;
      idx_q      <= '0;
      hold_cnt   <= '0;
      loaded     <= '0;
    end else begin
      dl_q   <= bus.ioctl_download;
      loaded <= loaded_next;
      if (dl_rise) idx_q <= bus.ioctl_index;
      case (state)
        S_IDLE: if (dl_rise) state <= S_LOAD;
        S_LOAD: begin
          if (dl_fall) begin
            if (all_req) begin
              state    <= S_HOLD;
              hold_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (dl_rise) begin
            state <= S_LOAD;
          end else begin
            if (hold_cnt != CW'(HOLD)) hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == CW'(HOLD - 1)) begin
              state      <= S_RUN;
              core_reset <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (dl_rise) begin
            state      <= S_LOAD;
            core_reset <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dip <= '0;
      mod <= '0;
    end else if (wr_strobe) begin
      if (bus.ioctl_index == IDX_DIP) begin
        for (int i = 0; i < DIPB; i++) begin
          if (bus.ioctl_addr == AW'(i)) dip[i*8 +: 8] <= bus.ioctl_dout;
        end
      end
      if (bus.ioctl_index == IDX_MOD && bus.ioctl_addr == '0) mod <= bus.ioctl_dout;
    end
  end

  dl_skid_buf #(
    .NREG (NREG),
    .AW   (AW),
    .IW   (IW)
  ) u_skid (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .wr_en      (region_wr),
    .wr_idx     (bus.ioctl_index[IW-1:0]),
    .wr_addr    (bus.ioctl_addr),
    .wr_data    (bus.ioctl_dout),
    .sink_ready (bus.sink_ready),
    .sink_wr    (bus.sink_wr),
    .sink_addr  (bus.sink_addr),
    .sink_data  (bus.sink_data),
    .ioctl_wait (bus.ioctl_wait)
  );

`ifdef DL_CHECKSUM_EN
  logic [NREG-1:0] acc_hit;
  assign acc_hit = bus.sink_wr & bus.sink_ready;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      csum       <= '0;
      csum_valid <= 1'b0;
    end else if (dl_rise) begin
      csum       <= '0;
      csum_valid <= 1'b0;
    end else begin
      if (|acc_hit) csum <= csum + bus.sink_data;
      if (state == S_LOAD && dl_fall) csum_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_arcade_dl_router.sv
// Directed-vector bench for arcade_dl_router (HOLD shortened to 8 cycles).
module tb_arcade_dl_router;

  localparam int HOLD_T = 8;

  typedef struct packed {
    logic [7:0]  region;
    logic [24:0] addr;
    logic [7:0]  data;
  } acc_t;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [63:0] dip;
  logic [7:0]  mod;
  logic        core_reset;
  logic [2:0]  loaded;
`ifdef DL_CHECKSUM_EN
  logic [7:0]  csum;
  logic        csum_valid;
`endif

  int   vecCount = 0;
  int   errCount = 0;
  int   waitCycles = 0;
  int   accCount = 0;
  acc_t accLog[64];

  arcade_dl_router_if #(.NREG(3), .AW(25)) bus ();

  arcade_dl_router #(
    .NREG (3),
    .AW   (25),
    .DIPB (8),
    .HOLD (HOLD_T)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus),
    .dip        (dip),
    .mod        (mod),
    .core_reset (core_reset),
    .loaded     (loaded)
`ifdef DL_CHECKSUM_EN
    ,
    .csum       (csum),
    .csum_valid (csum_valid)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // Sink-side monitor: logs every accepted region byte and counts stall cycles.
  always @(posedge clk_sys) begin
    if (bus.ioctl_wait) waitCycles++;
    for (int i = 0; i < 3; i++) begin
      if (bus.sink_wr[i] && bus.sink_ready[i] && accCount < 64) begin
        accLog[accCount] = '{8'(i), bus.sink_addr, bus.sink_data};
        accCount++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic startDownload(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic endDownload();
    bus.ioctl_download = 1'b0;
  endtask

  task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data);
    bus.ioctl_addr = addr;
    bus.ioctl_dout = data;
    bus.ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (bus.ioctl_wait && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("wait_release", 64'(bus.ioctl_wait), 64'd0);
    @(negedge clk_sys);
  endtask

  task automatic countResetCycles(output int n);
    n = 0;
    for (int k = 0; k < HOLD_T + 20; k++) begin
      @(negedge clk_sys);
      if (core_reset) n++;
      else break;
    end
  endtask

  initial begin
    int w0;
    int a0;
    int n;
    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_index    = '0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.sink_ready     = 3'b111;
    repeat (3) @(negedge clk_sys);
    checkOutput("rst_core_reset", 64'(core_reset), 64'd1);
    checkOutput("rst_wait", 64'(bus.ioctl_wait), 64'd0);
    checkOutput("rst_sink_wr", 64'(bus.sink_wr), 64'd0);
    checkOutput("rst_loaded", 64'(loaded), 64'd0);
    checkOutput("rst_mod", 64'(mod), 64'd0);
    checkOutput("rst_dip", dip, 64'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // DIP download, plus an out-of-range address that must be ignored
    $display("[TB] dip download");
    w0 = waitCycles;
    startDownload(8'd254);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(25'(i), 8'h11 + 8'(i));
      waitIdle();
    end
    applyStimulus(25'd8, 8'hEE);
    waitIdle();
    endDownload();
    @(negedge clk_sys);
    checkOutput("dip_value", dip, 64'h1817161514131211);
    checkOutput("dip_no_wait", 64'(waitCycles - w0), 64'd0);
    checkOutput("dip_loaded", 64'(loaded), 64'd0);
    checkOutput("dip_no_accept", 64'(accCount), 64'd0);

    // Region 0 with a 3-cycle sink stall on byte 1
    $display("[TB] region 0 download with stall");
    w0 = waitCycles;
    a0 = accCount;
    startDownload(8'd0);
    applyStimulus(25'd0, 8'hA0);
    waitIdle();
    bus.sink_ready[0] = 1'b0;
    applyStimulus(25'd1, 8'hA1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("stall_wait", 64'(bus.ioctl_wait), 64'd1);
      checkOutput("stall_addr", 64'(bus.sink_addr), 64'd1);
      checkOutput("stall_strobe", 64'(bus.sink_wr), 64'b001);
      @(negedge clk_sys);
    end
    bus.sink_ready[0] = 1'b1;
    #1;
    waitIdle();
    applyStimulus(25'd2, 8'hA2);
    waitIdle();
    applyStimulus(25'd3, 8'hA3);
    waitIdle();
    checkOutput("stall_wait_cycles", 64'(waitCycles - w0), 64'd3);
    checkOutput("r0_accept_count", 64'(accCount - a0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("r0_byte", 64'(accLog[a0 + i]), 64'({8'd0, 25'(i), 8'hA0 + 8'(i)}));
    end
    endDownload();
    @(negedge clk_sys);
    checkOutput("r0_loaded", 64'(loaded), 64'b001);
    countResetCycles(n);
    checkOutput("r0_core_reset_held", 64'(n), 64'(HOLD_T + 20));

    // Region 2 completes the required set; core reset drops after HOLD cycles
    $display("[TB] region 2 download");
    a0 = accCount;
    startDownload(8'd2);
    applyStimulus(25'd0, 8'hC3);
    waitIdle();
    checkOutput("r2_byte", 64'(accLog[a0]), 64'({8'd2, 25'd0, 8'hC3}));
    endDownload();
    countResetCycles(n);
    checkOutput("r2_hold_cycles", 64'(n), 64'(HOLD_T));
    checkOutput("r2_loaded", 64'(loaded), 64'b101);
    checkOutput("r2_run", 64'(core_reset), 64'd0);

    // Region 1 download from RUN: re-enters LOAD, captures mod from byte 0
    $display("[TB] region 1 download from run");
    a0 = accCount;
    startDownload(8'd1);
    checkOutput("r1_reload_reset", 64'(core_reset), 64'd1);
    applyStimulus(25'd0, 8'h5A);
    checkOutput("r1_mod_first", 64'(mod), 64'h5A);
    waitIdle();
    applyStimulus(25'd1, 8'h77);
    waitIdle();
    checkOutput("r1_mod_kept", 64'(mod), 64'h5A);
    checkOutput("r1_byte1", 64'(accLog[a0 + 1]), 64'({8'd1, 25'd1, 8'h77}));
    endDownload();
    countResetCycles(n);
    checkOutput("r1_hold_cycles", 64'(n), 64'(HOLD_T));
    checkOutput("r1_loaded", 64'(loaded), 64'b111);

    // Unmapped index: ignored, no wait, no strobe, no loaded change
    $display("[TB] unmapped index");
    a0 = accCount;
    startDownload(8'd7);
    applyStimulus(25'd0, 8'h99);
    checkOutput("ign_sink_wr", 64'(bus.sink_wr), 64'd0);
    checkOutput("ign_wait", 64'(bus.ioctl_wait), 64'd0);
    endDownload();
    @(negedge clk_sys);
    checkOutput("ign_accept", 64'(accCount - a0), 64'd0);
    checkOutput("ign_loaded", 64'(loaded), 64'b111);

    // Reset during a stalled region-2 write
    $display("[TB] reset during stalled write");
    startDownload(8'd2);
    bus.sink_ready[2] = 1'b0;
    applyStimulus(25'd5, 8'h33);
    checkOutput("stall2_strobe", 64'(bus.sink_wr), 64'b100);
    checkOutput("stall2_wait", 64'(bus.ioctl_wait), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_sink_wr", 64'(bus.sink_wr), 64'd0);
    checkOutput("mid_rst_wait", 64'(bus.ioctl_wait), 64'd0);
    checkOutput("mid_rst_loaded", 64'(loaded), 64'd0);
    @(negedge clk_sys);
    checkOutput("mid_rst_core_reset", 64'(core_reset), 64'd1);
    checkOutput("mid_rst_dip", dip, 64'd0);
    bus.ioctl_download = 1'b0;
    bus.sink_ready     = 3'b111;
    reset              = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    checkOutput("post_rst_loaded", 64'(loaded), 64'd0);
    checkOutput("post_rst_sink_wr", 64'(bus.sink_wr), 64'd0);

`ifdef DL_CHECKSUM_EN
    $display("[TB] checksum");
    startDownload(8'd0);
    applyStimulus(25'd0, 8'hFF);
    waitIdle();
    applyStimulus(25'd1, 8'h02);
    waitIdle();
    checkOutput("csum_valid_during", 64'(csum_valid), 64'd0);
    endDownload();
    @(negedge clk_sys);
    checkOutput("csum_value", 64'(csum), 64'h01);
    checkOutput("csum_valid_after", 64'(csum_valid), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
